// File: rtl/apb_controller.sv
// APB master state machine of the AHB-to-APB bridge: turns each accepted AHB transfer
// into one APB SETUP/ACCESS transfer and reports completion back to the AHB side.
module apb_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSEL   = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VALID,
  input  logic              HWRITE,
  input  logic [NSEL-1:0]   TSELx,
  input  logic [ADDR_W-1:0] TPADDR1,
  input  logic [ADDR_W-1:0] TPADDR2,
  input  logic [DATA_W-1:0] TPWDATA1,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output logic [NSEL-1:0]   PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              HREADYout,
  output logic [DATA_W-1:0] HRDATA,
  output logic [1:0]        HRESP
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RWAIT  = 3'd1,
    WWAIT1 = 3'd2,
    WWAIT2 = 3'd3,
    SETUP  = 3'd4,
    ACCESS = 3'd5
  } state_e;

  state_e            state_q;
  logic [NSEL-1:0]   sel_q;
  logic              wr_q;
  logic [NSEL-1:0]   psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  logic mapped_c;
  logic done_c;
  logic accept_c;

  // Unmapped transfers run the full sequence but never wait for a slave.
  assign mapped_c = |sel_q;
  assign done_c   = (state_q == ACCESS) && (PREADY || !mapped_c);
  assign accept_c = ((state_q == IDLE) || done_c) && VALID;

  // Reset is active-high on HRESETn, matching the rest of the bridge.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      wr_q      <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: ;
        RWAIT: begin
          paddr_q   <= TPADDR1;
          pwrite_q  <= 1'b0;
          psel_q    <= sel_q;
          penable_q <= 1'b0;
          state_q   <= SETUP;
        end
        WWAIT1: state_q <= WWAIT2;
        // Write data arrives one cycle after the address, hence the extra wait state.
        WWAIT2: begin
          paddr_q   <= TPADDR2;
          pwdata_q  <= TPWDATA1;
          pwrite_q  <= 1'b1;
          psel_q    <= sel_q;
          penable_q <= 1'b0;
          state_q   <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (done_c) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // A new transfer overrides the IDLE return so back-to-back transfers need no gap.
      if (accept_c) begin
        sel_q   <= TSELx;
        wr_q    <= HWRITE;
        state_q <= HWRITE ? WWAIT1 : RWAIT;
      end
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign HREADYout = (state_q == IDLE) || done_c;
  assign HRDATA    = ((state_q == ACCESS) && !wr_q && mapped_c) ? PRDATA : '0;
  assign HRESP     = 2'b00;

endmodule

// File: tb/tb_apb_controller.sv
// Bench for apb_controller: a directed cycle table for the documented sequences, then
// random AHB/APB traffic checked against a transaction-level scoreboard.
module tb_apb_controller;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        VALID = 1'b0;
  logic        HWRITE = 1'b0;
  logic [2:0]  TSELx = '0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [31:0] TPADDR1 = '0;
  logic [31:0] TPADDR2 = '0;
  logic [31:0] TPWDATA1 = '0;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        HREADYout;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  apb_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .VALID(VALID), .HWRITE(HWRITE), .TSELx(TSELx),
    .TPADDR1(TPADDR1), .TPADDR2(TPADDR2), .TPWDATA1(TPWDATA1),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .HREADYout(HREADYout), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Upstream AHB slave-interface pipeline
  always @(posedge HCLK) begin
    TPADDR1  <= HADDR;
    TPADDR2  <= TPADDR1;
    TPWDATA1 <= HWDATA;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rdfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic rst; logic v; logic w; logic [2:0] sel; logic [31:0] haddr; logic [31:0] hwdata;
    logic pready; logic [31:0] prdata;
    logic [2:0] psel; logic pen; logic pwr; logic [31:0] paddr; logic [31:0] pwdata;
    logic hrdy; logic [31:0] hrdata;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic rst, input logic v, input logic w, input logic [2:0] sel,
                              input logic [31:0] haddr, input logic [31:0] hwdata,
                              input logic pready, input logic [31:0] prdata,
                              input logic [2:0] psel, input logic pen, input logic pwr,
                              input logic [31:0] paddr, input logic [31:0] pwdata,
                              input logic hrdy, input logic [31:0] hrdata);
    vec_t r;
    r.rst = rst; r.v = v; r.w = w; r.sel = sel; r.haddr = haddr; r.hwdata = hwdata;
    r.pready = pready; r.prdata = prdata; r.psel = psel; r.pen = pen; r.pwr = pwr;
    r.paddr = paddr; r.pwdata = pwdata; r.hrdy = hrdy; r.hrdata = hrdata;
    vecs.push_back(r);
  endfunction

  typedef struct { logic w; logic [2:0] sel; logic [31:0] addr; logic [31:0] wdata; } txn_t;

  localparam int NTX = 300;
  localparam logic [31:0] A = 32'h8000_0010, B = 32'h8400_0004, C = 32'h8800_0008;
  localparam logic [31:0] D = 32'h8C00_0000, E = 32'h8000_0020, F = 32'h8000_0030;
  localparam logic [31:0] WD = 32'h1234_5678, WD2 = 32'hA5A5_A5A5;

  initial begin
    txn_t req, dp, t;
    txn_t apb_q[$];
    logic req_v, dp_v, stall_prev;
    logic [68:0] prev_bus, cur_bus;
    int lat, waits, n_issued, n_done;

    //   rst v w sel haddr  hwdata pr prdata         | psel en wr paddr pwdata hrdy hrdata
    add(1, 0, 0, 0, 0,     0,     1, 0,             0, 0, 0, 0, 0,   1, 0);
    add(0, 1, 0, 1, A,     0,     1, 32'hDEADBEEF,  0, 0, 0, 0, 0,   1, 0);
    add(0, 0, 0, 0, 0,     0,     1, 32'hDEADBEEF,  0, 0, 0, 0, 0,   0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 32'hDEADBEEF,  1, 0, 0, A, 0,   0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 32'hDEADBEEF,  1, 1, 0, A, 0,   1, 32'hDEADBEEF);
    add(0, 1, 1, 2, B,     0,     1, 0,             0, 0, 0, A, 0,   1, 0);
    add(0, 0, 0, 0, 0,     WD,    1, 0,             0, 0, 0, A, 0,   0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             0, 0, 0, A, 0,   0, 0);
    add(0, 0, 0, 0, 0,     0,     0, 0,             2, 0, 1, B, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     0, 0,             2, 1, 1, B, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     0, 0,             2, 1, 1, B, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     0, 0,             2, 1, 1, B, WD,  0, 0);
    add(0, 1, 0, 4, C,     0,     1, 0,             2, 1, 1, B, WD,  1, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             0, 0, 1, B, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             4, 0, 0, C, WD,  0, 0);
    add(0, 1, 0, 0, D,     0,     1, 32'hCAFEF00D,  4, 1, 0, C, WD,  1, 32'hCAFEF00D);
    add(0, 0, 0, 0, 0,     0,     1, 0,             0, 0, 0, C, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             0, 0, 0, D, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     0, 32'hFFFFFFFF,  0, 1, 0, D, WD,  1, 0);
    add(0, 1, 0, 1, E,     0,     1, 0,             0, 0, 0, D, WD,  1, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             0, 0, 0, D, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             1, 0, 0, E, WD,  0, 0);
    add(0, 0, 0, 0, 0,     0,     0, 32'h11112222,  1, 1, 0, E, WD,  0, 32'h11112222);
    add(1, 0, 0, 0, 0,     0,     0, 32'h11112222,  0, 0, 0, 0, 0,   1, 0);
    add(0, 1, 1, 4, F,     0,     1, 0,             0, 0, 0, 0, 0,   1, 0);
    add(0, 0, 0, 0, 0,     WD2,   1, 0,             0, 0, 0, 0, 0,   0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             0, 0, 0, 0, 0,   0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             4, 0, 1, F, WD2, 0, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             4, 1, 1, F, WD2, 1, 0);
    add(0, 0, 0, 0, 0,     0,     1, 0,             0, 0, 1, F, WD2, 1, 0);

    foreach (vecs[i]) begin
      @(negedge HCLK);
      HRESETn = vecs[i].rst; VALID = vecs[i].v; HWRITE = vecs[i].w; TSELx = vecs[i].sel;
      HADDR = vecs[i].haddr; HWDATA = vecs[i].hwdata; PREADY = vecs[i].pready;
      PRDATA = vecs[i].prdata;
      #1;
      chk($sformatf("vec%0d", i),
          {PSEL, PENABLE, PWRITE, PADDR, PWDATA, HREADYout, HRDATA, HRESP},
          {vecs[i].psel, vecs[i].pen, vecs[i].pwr, vecs[i].paddr, vecs[i].pwdata,
           vecs[i].hrdy, vecs[i].hrdata, 2'b00});
    end

    // Random traffic
    @(negedge HCLK);
    HRESETn = 1'b1; VALID = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b0;
    req_v = 1'b0; dp_v = 1'b0; stall_prev = 1'b0; prev_bus = '0;
    lat = 0; waits = 0; n_issued = 0; n_done = 0;
    req = '{w: 1'b0, sel: 3'b0, addr: 32'h0, wdata: 32'h0};
    dp = req;
    for (int cyc = 0; cyc < 20000 && n_done < NTX; cyc++) begin
      if (cyc != 0) @(negedge HCLK);
      PREADY = ($urandom_range(0, 3) != 0);
      PRDATA = rdfn(PADDR);
      if (!req_v && n_issued < NTX && $urandom_range(0, 2) != 0) begin
        req.w = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: req.sel = 3'b000;
          1: req.sel = 3'b001;
          2: req.sel = 3'b010;
          default: req.sel = 3'b100;
        endcase
        req.addr  = $urandom() & 32'hFFFF_FFFC;
        req.wdata = $urandom();
        req_v = 1'b1;
        n_issued++;
      end
      VALID  = req_v;
      HWRITE = req.w;
      TSELx  = req.sel;
      HADDR  = req_v ? req.addr : $urandom();
      HWDATA = (dp_v && dp.w) ? dp.wdata : $urandom();
      #1;
      cur_bus = {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
      if (PSEL != 3'b000)
        chk("psel_legal", 128'(PSEL), 128'((apb_q.size() > 0) ? apb_q[0].sel : 3'b000));
      if (stall_prev) chk("apb_stable", 128'(cur_bus), 128'(prev_bus));
      if (PSEL != 3'b000 && PENABLE && PREADY) begin
        if (apb_q.size() > 0) begin
          t = apb_q.pop_front();
          chk("apb_xfer", {PSEL, PWRITE, PADDR, PWRITE ? PWDATA : 32'h0},
              {t.sel, t.w, t.addr, t.w ? t.wdata : 32'h0});
        end else begin
          chk("apb_unexpected", 128'(PSEL), 128'(0));
        end
      end
      stall_prev = (PSEL != 3'b000) && PENABLE && !PREADY;
      prev_bus = cur_bus;
      if (dp_v) begin
        lat++;
        if (PSEL != 3'b000 && PENABLE && !PREADY) waits++;
        if (HREADYout) begin
          chk("latency", 128'(lat), 128'((dp.w ? 4 : 3) + waits));
          if (!dp.w)
            chk("hrdata", 128'(HRDATA), 128'((dp.sel != 3'b000) ? rdfn(dp.addr) : 32'h0));
          chk("hresp", 128'(HRESP), 128'(0));
          dp_v = 1'b0;
          n_done++;
        end else if (lat > 64) begin
          n_checks++;
          $display("FAIL timeout: transfer still pending after %0d cycles, required at most 64", lat);
          dp_v = 1'b0;
          n_done++;
        end
      end
      if (req_v && HREADYout) begin
        if (req.sel != 3'b000) apb_q.push_back(req);
        dp = req; dp_v = 1'b1; lat = 0; waits = 0; req_v = 1'b0;
      end
    end
    chk("all_done", 128'(n_done), 128'(NTX));
    chk("apb_q_empty", 128'(apb_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
